// File: rtl/invader_pixel_gen.sv
// Invader formation pixel generator: renders the alive alien grid from the VGA
// pixel position and owns formation motion (march, drop, land) and the alive mask.
`timescale 1ns/1ps
module invader_pixel_gen #(
  parameter int ROWS        = 5,
  parameter int COLS        = 8,
  parameter int X0          = 64,
  parameter int Y0          = 48,
  parameter int STEP        = 4,
  parameter int DROP_PX     = 8,
  parameter int MOVE_FRAMES = 30,
  parameter int BOTTOM      = 440
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pause,
  input  logic        kill_valid,
  input  logic [2:0]  kill_row,
  input  logic [2:0]  kill_col,
  output logic [11:0] rgb,
  output logic [9:0]  form_x,
  output logic [9:0]  form_y,
  output logic        landed,
  output logic        all_dead
);
  localparam int W  = 32*(COLS-1) + 16;
  localparam int H  = 24*(ROWS-1) + 16;
  localparam int N  = ROWS*COLS;
  localparam int IW = $clog2(N);
  localparam logic [11:0] ALIEN_RGB = 12'h0F0;

  typedef enum logic [2:0] {MOVE_R, MOVE_L, DROP_TO_L, DROP_TO_R, LANDED} state_t;

  state_t        r_state;
  logic [5:0]    r_frame_cnt;
  logic [N-1:0]  r_alive;
  logic [11:0]   r_rgb;
  logic [9:0]    r_form_x;
  logic [9:0]    r_form_y;
  logic          r_landed;
  logic          r_all_dead;

  logic [10:0]   w_relx;
  logic [10:0]   w_rely;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_pix_on;
  logic [2:0]    w_col;
  logic [2:0]    w_row;
  logic [2:0]    w_scol;
  logic [2:0]    w_srow;
  logic [7:0]    w_bits;
  logic [IW-1:0] w_cell_idx;
  logic [IW-1:0] w_kill_idx;
  logic          w_kill_ok;
  logic          w_frame_tick;
  logic          w_adv;
  logic          w_move;
  logic          w_hit_right;
  logic          w_hit_left;
  logic          w_land;
  logic [9:0]    w_y_drop;

  function automatic logic [7:0] sprite_row(input logic [2:0] idx);
    case (idx)
      3'd0:    sprite_row = 8'h18;
      3'd1:    sprite_row = 8'h3C;
      3'd2:    sprite_row = 8'h7E;
      3'd3:    sprite_row = 8'hDB;
      3'd4:    sprite_row = 8'hFF;
      3'd5:    sprite_row = 8'h24;
      3'd6:    sprite_row = 8'h5A;
      default: sprite_row = 8'hA5;
    endcase
  endfunction

  // Columns sit on a 32-pixel pitch, so the column falls out of the offset bits;
  // rows use a 24-pixel pitch and are matched against each row band instead.
  always_comb begin
    w_relx = {1'b0, x} - {1'b0, r_form_x};
    w_rely = {1'b0, y} - {1'b0, r_form_y};
    w_in_x = (x >= r_form_x) && ((w_relx >> 5) < 11'(COLS)) && !w_relx[4];
    w_col  = w_relx[7:5];
    w_scol = w_relx[3:1];
    w_in_y = 1'b0;
    w_row  = 3'd0;
    w_srow = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      if ((y >= r_form_y) && (w_rely >= 11'(24*r)) && (w_rely < 11'(24*r + 16))) begin
        w_in_y = 1'b1;
        w_row  = 3'(r);
        w_srow = 3'((w_rely - 11'(24*r)) >> 1);
      end
    end
    w_cell_idx = IW'(w_row) * IW'(COLS) + IW'(w_col);
    w_bits     = sprite_row(w_srow);
    w_pix_on   = w_in_x && w_in_y && r_alive[w_cell_idx] && w_bits[3'd7 - w_scol];
  end

  assign w_kill_ok    = kill_valid && ({1'b0, kill_row} < 4'(ROWS)) && ({1'b0, kill_col} < 4'(COLS));
  assign w_kill_idx   = IW'(kill_row) * IW'(COLS) + IW'(kill_col);
  assign w_frame_tick = p_tick && (x == 10'd0) && (y == 10'd480);
  assign w_adv        = w_frame_tick && !pause && (r_state != LANDED);
  assign w_move       = w_adv && (r_frame_cnt == 6'(MOVE_FRAMES-1));
  assign w_hit_right  = ({1'b0, r_form_x} + 11'(W + STEP)) > 11'd640;
  assign w_hit_left   = r_form_x < 10'(STEP);
  assign w_y_drop     = r_form_y + 10'(DROP_PX);
  assign w_land       = ({1'b0, w_y_drop} + 11'(H)) >= 11'(BOTTOM);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb       <= 12'h000;
      r_form_x    <= 10'(X0);
      r_form_y    <= 10'(Y0);
      r_landed    <= 1'b0;
      r_all_dead  <= 1'b0;
      r_alive     <= '1;
      r_frame_cnt <= 6'd0;
      r_state     <= MOVE_R;
    end else begin
      if (p_tick)
        r_rgb <= (video_on && w_pix_on) ? ALIEN_RGB : 12'h000;
      if (w_kill_ok)
        r_alive[w_kill_idx] <= 1'b0;
      r_all_dead <= (r_alive == '0);
      if (w_adv)
        r_frame_cnt <= (r_frame_cnt == 6'(MOVE_FRAMES-1)) ? 6'd0 : r_frame_cnt + 6'd1;
      if (w_move) begin
        case (r_state)
          MOVE_R: begin
            if (w_hit_right) r_state <= DROP_TO_L;
            else             r_form_x <= r_form_x + 10'(STEP);
          end
          MOVE_L: begin
            if (w_hit_left) r_state <= DROP_TO_R;
            else            r_form_x <= r_form_x - 10'(STEP);
          end
          DROP_TO_L, DROP_TO_R: begin
            r_form_y <= w_y_drop;
            if (w_land) begin
              r_state  <= LANDED;
              r_landed <= 1'b1;
            end else begin
              r_state <= (r_state == DROP_TO_L) ? MOVE_L : MOVE_R;
            end
          end
          default: r_state <= LANDED;
        endcase
      end
    end
  end

  assign rgb      = r_rgb;
  assign form_x   = r_form_x;
  assign form_y   = r_form_y;
  assign landed   = r_landed;
  assign all_dead = r_all_dead;

endmodule
